// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared types for the gate sweep tester.
//   op_e    : gate select codes (6 and 7 are illegal)
//   state_e : sweep controller states
//   OP_W    : width of the gate select field
package gate_sweep_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_e;

endpackage

// File: rtl/logic_gate_ref.sv
// logic_gate_ref: combinational golden model of a WIDTH-bit bitwise 2-input gate.
//   op : gate select (op_e encoding); illegal codes produce all zeros
//   a  : operand A
//   b  : operand B
//   y  : expected gate output
module logic_gate_ref
    import gate_sweep_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_tester.sv
// gate_sweep_tester: exhaustive in-circuit checker for a WIDTH-bit 2-input gate.
// Steps all 2**(2*WIDTH) operand pairs, holds each HOLD_CYCLES cycles, then
// compares y_in against the golden model and accumulates mismatches.
//   clk, rst      : clock, synchronous active-high reset
//   start, op     : sweep request and gate select (latched on accept)
//   a_out, b_out  : operands to gate under test (upper/lower halves of vec)
//   y_in          : gate under test output
//   busy, done    : sweep in progress / result valid
//   pass, bad_op  : result flags, meaningful while done
//   err_count     : mismatching vectors in the last sweep
//   first_err_vec : vec index of the first mismatch (0 if none)
module gate_sweep_tester
    import gate_sweep_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           op,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic [WIDTH-1:0]     y_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 bad_op,
    output logic [2*WIDTH:0]     err_count,
    output logic [2*WIDTH-1:0]   first_err_vec
);

    localparam int VW = 2 * WIDTH;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [VW-1:0] VEC_LAST = '1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    state_e          state_q, state_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            bad_q, bad_d;
    logic [VW:0]     err_q, err_d;
    logic [VW-1:0]   fev_q, fev_d;
    logic [WIDTH-1:0] golden;

    // Golden model sees only registered state, so no path from y_in/start to outputs.
    logic_gate_ref #(.WIDTH(WIDTH)) u_ref (
        .op (op_q),
        .a  (vec_q[VW-1:WIDTH]),
        .b  (vec_q[WIDTH-1:0]),
        .y  (golden)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            hold_q  <= '0;
            op_q    <= '0;
            bad_q   <= 1'b0;
            err_q   <= '0;
            fev_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            op_q    <= op_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hold_d  = hold_q;
        op_d    = op_q;
        bad_d   = bad_q;
        err_d   = err_q;
        fev_d   = fev_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    err_d = '0;
                    fev_d = '0;
                    if (op <= 3'(OP_XNOR)) begin
                        op_d    = op;
                        vec_d   = '0;
                        hold_d  = '0;
                        bad_d   = 1'b0;
                        state_d = DRIVE;
                    end else begin
                        bad_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DRIVE: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            SAMPLE: begin
                if (y_in != golden) begin
                    err_d = err_q + 1'b1;
                    if (err_q == '0) begin
                        fev_d = vec_q;
                    end
                end
                if (vec_q == VEC_LAST) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    hold_d  = '0;
                    state_d = DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign a_out         = vec_q[VW-1:WIDTH];
    assign b_out         = vec_q[WIDTH-1:0];
    assign busy          = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done          = (state_q == DONE);
    assign pass          = (state_q == DONE) && (err_q == '0) && !bad_q;
    assign bad_op        = bad_q;
    assign err_count     = err_q;
    assign first_err_vec = fev_q;

endmodule
